eim_stream_bridge: RTL



---
 rtl/eim_stream_bridge.sv | 135 +++++++++++++
 1 files changed

// File: rtl/eim_stream_bridge.sv
// EIM bus bridge: register bank, TX window feeding a FWFT FIFO towards the RF stream,
// and RX window popping a FIFO filled by the RF stream. Single clock domain.
`timescale 1ns/1ps
module eim_stream_bridge #(
    parameter int          TX_AW   = 10,
    parameter int          RX_AW   = 10,
    parameter logic [15:0] VERSION = 16'h0001
) (
    input  logic        bus_clk,
    input  logic        reset,
    input  logic        bus_sel,
    input  logic        bus_wr,
    input  logic [18:0] bus_addr,
    input  logic [15:0] bus_data_wr,
    output logic [15:0] bus_data_rd,
    output logic        bus_rdy,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int TX_D = 1 << TX_AW;
    localparam int RX_D = 1 << RX_AW;

    logic [15:0]    r_tx_mem [TX_D];
    logic [15:0]    r_rx_mem [RX_D];
    logic [TX_AW:0] r_tx_wp, r_tx_rp;
    logic [RX_AW:0] r_rx_wp, r_rx_rp;
    logic           r_tx_en, r_rx_en;
    logic [1:0]     r_flags;
    logic [15:0]    r_rd_data;

    logic [2:0]     w_win;
    logic           w_reg_wr, w_tx_beat, w_rx_beat, w_clr;
    logic           w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_tx_ovf;
    logic           w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_unf;
    logic [TX_AW:0] w_tx_level;
    logic [RX_AW:0] w_rx_level;
    logic [1:0]     w_flag_clr;
    logic [15:0]    w_rd_data;
    logic           w_unused;

    assign w_win     = bus_addr[18:16];
    assign w_reg_wr  = bus_sel &  bus_wr & (w_win == 3'd0);
    assign w_tx_beat = bus_sel &  bus_wr & (w_win == 3'd1);
    assign w_rx_beat = bus_sel & ~bus_wr & (w_win == 3'd2);
    assign w_clr     = w_reg_wr & (bus_addr[3:0] == 4'h1) & bus_data_wr[2];
    assign w_unused  = &{1'b0, bus_addr[15:4]};

    // TX FIFO: a pop in the same cycle frees the slot, so a push into a full FIFO is accepted
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[TX_AW] != r_tx_rp[TX_AW]) &&
                        (r_tx_wp[TX_AW-1:0] == r_tx_rp[TX_AW-1:0]);
    assign tx_valid   = r_tx_en & ~w_tx_empty;
    assign tx_data    = r_tx_mem[r_tx_rp[TX_AW-1:0]];
    assign w_tx_pop   = tx_valid & tx_ready;
    assign w_tx_push  = w_tx_beat & (~w_tx_full | w_tx_pop);
    assign w_tx_ovf   = w_tx_beat & w_tx_full & ~w_tx_pop;
    assign w_tx_level = r_tx_wp - r_tx_rp;
    assign bus_rdy    = ~w_tx_full;

    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[RX_AW] != r_rx_rp[RX_AW]) &&
                        (r_rx_wp[RX_AW-1:0] == r_rx_rp[RX_AW-1:0]);
    assign rx_ready   = r_rx_en & ~w_rx_full;
    assign w_rx_push  = rx_valid & rx_ready;
    assign w_rx_pop   = w_rx_beat & ~w_rx_empty;
    assign w_rx_unf   = w_rx_beat & w_rx_empty;
    assign w_rx_level = r_rx_wp - r_rx_rp;

    always_ff @(posedge bus_clk) begin
        if (w_tx_push && !reset) r_tx_mem[r_tx_wp[TX_AW-1:0]] <= bus_data_wr;
        if (w_rx_push && !reset) r_rx_mem[r_rx_wp[RX_AW-1:0]] <= rx_data;
    end

    // clr outranks any push or pop in the same cycle
    always_ff @(posedge bus_clk) begin
        if (reset || w_clr) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
        end
    end

    assign w_flag_clr = (w_reg_wr && bus_addr[3:0] == 4'h4) ? bus_data_wr[1:0] : 2'b00;

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            r_tx_en <= 1'b0;
            r_rx_en <= 1'b0;
            r_flags <= 2'b00;
        end else begin
            if (w_reg_wr && bus_addr[3:0] == 4'h1) begin
                r_tx_en <= bus_data_wr[0];
                r_rx_en <= bus_data_wr[1];
            end
            r_flags <= (r_flags & ~w_flag_clr) | {w_rx_unf, w_tx_ovf};
        end
    end

    always_comb begin
        w_rd_data = 16'h0000;
        case (w_win)
            3'd0: begin
                case (bus_addr[3:0])
                    4'h0:    w_rd_data = VERSION;
                    4'h1:    w_rd_data = {14'd0, r_rx_en, r_tx_en};
                    4'h2:    w_rd_data = 16'(w_tx_level);
                    4'h3:    w_rd_data = 16'(w_rx_level);
                    4'h4:    w_rd_data = {14'd0, r_flags};
                    default: w_rd_data = 16'h0000;
                endcase
            end
            3'd2:    w_rd_data = w_rx_empty ? 16'h0000 : r_rx_mem[r_rx_rp[RX_AW-1:0]];
            default: w_rd_data = 16'h0000;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (reset)                 r_rd_data <= 16'h0000;
        else if (bus_sel && !bus_wr) r_rd_data <= w_rd_data;
    end

    assign bus_data_rd = r_rd_data;

endmodule
